// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operand-issue stage: widths, mode
// encodings and the operand-source priority helper.
package alu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned MODE_W    = 4;
    localparam int unsigned REG_IDX_W = $clog2(NREG);
    localparam int unsigned SHAMT_W   = $clog2(XLEN);

    // Defined ALU operations; codes above ALU_MODE_MAX are reserved.
    typedef enum logic [MODE_W-1:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_mode_e;

    localparam logic [MODE_W-1:0] ALU_MODE_MAX = 4'd8;

    // True for the three shift operations, whose B operand is a shift amount.
    function automatic logic is_shift(input logic [MODE_W-1:0] mode);
        return (mode == ALU_SLL) || (mode == ALU_SRL) || (mode == ALU_SRA);
    endfunction

    // Source operand selection, highest priority first: x0, result of the
    // instruction leaving EX this cycle, value being written back this cycle,
    // then the stored register value.
    function automatic logic [XLEN-1:0] resolve_src(
        input logic [REG_IDX_W-1:0] rs,
        input logic [XLEN-1:0]      rf_val,
        input logic                 ex_en,
        input logic [REG_IDX_W-1:0] ex_rd,
        input logic [XLEN-1:0]      ex_val,
        input logic                 wb_en,
        input logic [REG_IDX_W-1:0] wb_rd,
        input logic [XLEN-1:0]      wb_val
    );
        logic [XLEN-1:0] val;
        if (rs == '0) begin
            val = '0;
        end else if (ex_en && (ex_rd == rs)) begin
            val = ex_val;
        end else if (wb_en && (wb_rd == rs)) begin
            val = wb_val;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Issue, ALU-side and writeback signals of the operand stage. The stage uses
// the slave view; whoever feeds it and consumes its outputs uses master.
interface alu_operand_stage_if;
    import alu_pkg::*;

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [MODE_W-1:0]    in_mode;
    logic [REG_IDX_W-1:0] in_rs1;
    logic [REG_IDX_W-1:0] in_rs2;
    logic [REG_IDX_W-1:0] in_rd;
    logic [XLEN-1:0]      in_imm;
    logic                 in_use_imm;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_a;
    logic [XLEN-1:0]      out_b;
    logic [MODE_W-1:0]    out_mode;
    logic [REG_IDX_W-1:0] out_rd;
    logic                 out_illegal;

    logic [XLEN-1:0]      alu_x;

    logic                 wb_en;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_data;

    modport slave (
        input  flush, in_valid, in_mode, in_rs1, in_rs2, in_rd, in_imm, in_use_imm,
        input  out_ready, alu_x, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_a, out_b, out_mode, out_rd, out_illegal
    );

    modport master (
        output flush, in_valid, in_mode, in_rs1, in_rs2, in_rd, in_imm, in_use_imm,
        output out_ready, alu_x, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_a, out_b, out_mode, out_rd, out_illegal
    );

endinterface

// File: rtl/alu_operand_stage_reg_file.sv
// Architectural register file: two asynchronous read ports, one write port,
// x0 hardwired to zero. Same-cycle write-to-read bypass is done by the parent.
module reg_file
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] raddr1,
    output logic [XLEN-1:0]      rdata1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [XLEN-1:0]      rdata2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Next register contents: apply the write unless it targets x0.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Register storage, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports; x0 reads zero regardless of storage.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-issue stage in front of the ALU: holds the register file and the
// ID/EX register, resolves operands with EX forwarding and WB bypass, and
// presents sanitised A, B and mode to the ALU over a valid/ready handshake.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave io
);

    logic                 out_valid_q,   out_valid_d;
    logic [XLEN-1:0]      out_a_q,       out_a_d;
    logic [XLEN-1:0]      out_b_q,       out_b_d;
    logic [MODE_W-1:0]    out_mode_q,    out_mode_d;
    logic [REG_IDX_W-1:0] out_rd_q,      out_rd_d;
    logic                 out_illegal_q, out_illegal_d;

    logic                 in_ready;
    logic                 capture;
    logic                 transfer;
    logic                 ex_fwd_en;

    logic [XLEN-1:0]      rf_rdata1;
    logic [XLEN-1:0]      rf_rdata2;
    logic                 rf_we;

    logic [XLEN-1:0]      src_a;
    logic [XLEN-1:0]      src_rs2;
    logic [XLEN-1:0]      src_b;
    logic                 mode_illegal;
    logic [MODE_W-1:0]    mode_clean;
    logic [XLEN-1:0]      b_clean;

    assign rf_we = io.wb_en && (io.wb_rd != '0);

    reg_file u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (io.in_rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (io.in_rs2),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (io.wb_rd),
        .wdata  (io.wb_data)
    );

    // Handshake: accept when not flushing and the held slot is empty or leaving.
    always_comb begin
        in_ready  = rst_n && !io.flush && (!out_valid_q || io.out_ready);
        capture   = io.in_valid && in_ready;
        transfer  = out_valid_q && io.out_ready;
        ex_fwd_en = transfer && (out_rd_q != '0);
    end

    // Operand resolution for both sources plus immediate selection for B.
    always_comb begin
        src_a   = resolve_src(io.in_rs1, rf_rdata1, ex_fwd_en, out_rd_q, io.alu_x,
                              io.wb_en, io.wb_rd, io.wb_data);
        src_rs2 = resolve_src(io.in_rs2, rf_rdata2, ex_fwd_en, out_rd_q, io.alu_x,
                              io.wb_en, io.wb_rd, io.wb_data);
        src_b   = io.in_use_imm ? io.in_imm : src_rs2;
    end

    // Reserved modes become NOP; shifts only ever see a 5-bit amount.
    always_comb begin
        mode_illegal = (io.in_mode > ALU_MODE_MAX);
        mode_clean   = mode_illegal ? MODE_W'(ALU_NOP) : io.in_mode;
        if (is_shift(mode_clean)) begin
            b_clean = {{(XLEN-SHAMT_W){1'b0}}, src_b[SHAMT_W-1:0]};
        end else begin
            b_clean = src_b;
        end
    end

    // ID/EX register next state: flush wins, then capture, then drain on transfer.
    // Payload is left untouched on flush and drain; it is don't-care while invalid.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_mode_d    = out_mode_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        if (io.flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d   = 1'b1;
            out_a_d       = src_a;
            out_b_d       = b_clean;
            out_mode_d    = mode_clean;
            out_rd_d      = io.in_rd;
            out_illegal_d = mode_illegal;
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_mode_q    <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_mode_q    <= out_mode_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Drive the interface outputs from the held state.
    always_comb begin
        io.in_ready    = in_ready;
        io.out_valid   = out_valid_q;
        io.out_a       = out_a_q;
        io.out_b       = out_b_q;
        io.out_mode    = out_mode_q;
        io.out_rd      = out_rd_q;
        io.out_illegal = out_illegal_q;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboarded bench for alu_operand_stage. The bench plays the decoder, the
// ALU and the writeback stage; expected operands come from an in-order
// architectural register model.
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_operand_stage_if bus();

    alu_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  mode;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic        v;
        logic [3:0]  m;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ui;
        logic        ordy;
        logic        fl;
        logic        xwb_en;
        logic [4:0]  xwb_rd;
        logic [31:0] xwb_data;
        logic        xalu_en;
        logic [31:0] xalu;
    } stim_t;

    exp_t        q[$];
    logic [31:0] arch [32];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        exp_in_ready = 1'b0;
    logic        pend_v = 1'b0;
    logic [4:0]  pend_rd = '0;
    logic [31:0] pend_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written directly from the operation list.
    function automatic logic [31:0] alu_ref(input logic [3:0] m, input logic [31:0] a,
                                            input logic [31:0] b);
        case (m)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.v = 1'b0; s.m = '0; s.r1 = '0; s.r2 = '0; s.rd = '0; s.imm = '0; s.ui = 1'b0;
        s.ordy = 1'b1; s.fl = 1'b0; s.xwb_en = 1'b0; s.xwb_rd = '0; s.xwb_data = '0;
        s.xalu_en = 1'b0; s.xalu = '0;
        return s;
    endfunction

    function automatic logic [4:0] rand_reg();
        if ($urandom_range(0, 9) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle();
        s.v        = ($urandom_range(0, 3) != 0);
        s.m        = 4'($urandom);
        s.r1       = rand_reg();
        s.r2       = rand_reg();
        s.rd       = rand_reg();
        s.imm      = $urandom;
        s.ui       = $urandom_range(0, 1) == 1;
        s.ordy     = ($urandom_range(0, 3) != 0);
        s.fl       = ($urandom_range(0, 15) == 0);
        s.xwb_en   = ($urandom_range(0, 7) == 0);
        s.xwb_rd   = rand_reg();
        s.xwb_data = $urandom;
        return s;
    endfunction

    // Monitor: compares the held instruction against the scoreboard head and
    // retires it when the downstream accepts.
    always @(negedge clk) begin
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_in_ready});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_a", bus.out_a, q[0].a);
            chk("out_b", bus.out_b, q[0].b);
            chk("out_mode", {28'd0, bus.out_mode}, {28'd0, q[0].mode});
            chk("out_rd", {27'd0, bus.out_rd}, {27'd0, q[0].rd});
            chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, q[0].ill});
            if (bus.out_ready) void'(q.pop_front());
        end
    end

    // One cycle of stimulus, entered and left just after a rising edge.
    task automatic drive(input stim_t s);
        bit          held;
        bit          xfer;
        bit          cap;
        logic [31:0] res;
        logic [31:0] braw;
        exp_t        e;
        bit          nv;
        logic [4:0]  nrd;

        held = (q.size() != 0);
        bus.in_valid   = s.v;
        bus.in_mode    = s.m;
        bus.in_rs1     = s.r1;
        bus.in_rs2     = s.r2;
        bus.in_rd      = s.rd;
        bus.in_imm     = s.imm;
        bus.in_use_imm = s.ui;
        bus.out_ready  = s.ordy;
        bus.flush      = s.fl;

        if (pend_v) begin
            bus.wb_en = 1'b1; bus.wb_rd = pend_rd; bus.wb_data = pend_data;
        end else if (s.xwb_en) begin
            bus.wb_en = 1'b1; bus.wb_rd = s.xwb_rd; bus.wb_data = s.xwb_data;
            if (s.xwb_rd != 0) arch[s.xwb_rd] = s.xwb_data;
        end else begin
            bus.wb_en = 1'b0; bus.wb_rd = 5'($urandom); bus.wb_data = $urandom;
        end

        if (held) res = s.xalu_en ? s.xalu : alu_ref(q[0].mode, q[0].a, q[0].b);
        else      res = s.xalu_en ? s.xalu : $urandom;
        bus.alu_x = res;

        xfer = held && s.ordy;
        nv   = xfer;
        nrd  = held ? q[0].rd : 5'd0;
        if (xfer && q[0].rd != 0) arch[q[0].rd] = res;

        exp_in_ready = !s.fl && (!held || s.ordy);
        cap = s.v && exp_in_ready;
        if (cap) begin
            e.ill  = (s.m > 4'd8);
            e.mode = e.ill ? 4'd0 : s.m;
            e.a    = arch[s.r1];
            braw   = s.ui ? s.imm : arch[s.r2];
            e.b    = (e.mode >= 4'd6 && e.mode <= 4'd8) ? (braw % 32) : braw;
            e.rd   = s.rd;
        end

        @(posedge clk);
        if (s.fl && held && !s.ordy) void'(q.pop_front());
        if (cap) q.push_back(e);
        pend_v    = nv;
        pend_rd   = nrd;
        pend_data = res;
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        for (int i = 0; i < 32; i++) arch[i] = '0;
        pend_v = 1'b0;
        exp_in_ready = 1'b0;
    endtask

    initial begin
        stim_t s;
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_mode = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_rd = '0; bus.in_imm = '0; bus.in_use_imm = 1'b0;
        bus.out_ready = 1'b0; bus.alu_x = '0; bus.wb_en = 1'b0; bus.wb_rd = '0;
        bus.wb_data = '0;
        clear_model();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_a", bus.out_a, 32'd0);
        rst_n = 1'b1;

        // Write x5, then ADD x5 + 3 into x7.
        s = idle(); s.xwb_en = 1'b1; s.xwb_rd = 5'd5; s.xwb_data = 32'h10; drive(s);
        s = idle(); s.v = 1'b1; s.m = 4'd1; s.r1 = 5'd5; s.rd = 5'd7; s.ui = 1'b1;
        s.imm = 32'h3; drive(s);
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_a", bus.out_a, 32'h10);
        chk("add_b", bus.out_b, 32'h3);
        chk("add_mode", {28'd0, bus.out_mode}, 32'd1);

        // Dependent instruction while x7's producer leaves with result 0x55.
        s = idle(); s.v = 1'b1; s.m = 4'd1; s.r1 = 5'd7; s.rd = 5'd8; s.ui = 1'b1;
        s.xalu_en = 1'b1; s.xalu = 32'h55; drive(s);
        chk("ex_fwd_a", bus.out_a, 32'h55);
        s = idle(); s.v = 1'b1; s.m = 4'd2; s.r2 = 5'd7; s.rd = 5'd9; drive(s);
        chk("wb_bypass_b", bus.out_b, 32'h55);

        // Backpressure for three cycles, then release.
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.v = 1'b1; s.m = 4'd3; s.r1 = 5'd1; s.rd = 5'd10; s.ordy = 1'b0;
            drive(s);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_hold_b", bus.out_b, 32'h55);
            chk("bp_hold_rd", {27'd0, bus.out_rd}, 32'd9);
        end
        s = idle(); s.v = 1'b1; s.m = 4'd3; s.r1 = 5'd1; s.rd = 5'd10; drive(s);
        chk("bp_release_rd", {27'd0, bus.out_rd}, 32'd10);

        // Reserved mode, then SRA with an oversized immediate.
        s = idle(); s.v = 1'b1; s.m = 4'd12; s.rd = 5'd11; drive(s);
        chk("rsvd_mode", {28'd0, bus.out_mode}, 32'd0);
        chk("rsvd_illegal", {31'd0, bus.out_illegal}, 32'd1);
        s = idle(); s.v = 1'b1; s.m = 4'd8; s.ui = 1'b1; s.imm = 32'hFFFF_FFE3; s.rd = 5'd12;
        drive(s);
        chk("sra_b", bus.out_b, 32'h3);
        chk("sra_illegal", {31'd0, bus.out_illegal}, 32'd0);
        for (int i = 0; i < 3; i++) drive(idle());

        // x0: same-cycle write attempt, then a held rd=0 result on alu_x.
        s = idle(); s.xwb_en = 1'b1; s.xwb_rd = 5'd0; s.xwb_data = 32'hDEAD_BEEF;
        s.v = 1'b1; s.m = 4'd1; s.rd = 5'd0; drive(s);
        chk("x0_wb_a", bus.out_a, 32'd0);
        s = idle(); s.v = 1'b1; s.m = 4'd4; s.ui = 1'b1; s.imm = 32'h77; s.rd = 5'd13;
        s.xalu_en = 1'b1; s.xalu = 32'h1234; drive(s);
        chk("x0_fwd_a", bus.out_a, 32'd0);

        // Flush a stalled instruction while a new one is offered.
        s = idle(); s.v = 1'b1; s.m = 4'd1; s.rd = 5'd14; s.fl = 1'b1; s.ordy = 1'b0;
        drive(s);
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        drive(idle());
        chk("flush_no_cap", {31'd0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 1500; i++) drive(rand_stim());

        // Asynchronous reset in the middle of traffic.
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.wb_en = 1'b0;
        clear_model();
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_a", bus.out_a, 32'd0);
        chk("mid_rst_b", bus.out_b, 32'd0);
        chk("mid_rst_mode", {28'd0, bus.out_mode}, 32'd0);
        chk("mid_rst_rd", {27'd0, bus.out_rd}, 32'd0);
        chk("mid_rst_illegal", {31'd0, bus.out_illegal}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Register written before reset must read back as zero.
        s = idle(); s.v = 1'b1; s.m = 4'd1; s.r1 = 5'd5; s.ui = 1'b1; s.rd = 5'd3; drive(s);
        chk("post_rst_x5", bus.out_a, 32'd0);

        for (int i = 0; i < 500; i++) drive(rand_stim());
        for (int i = 0; i < 3; i++) drive(idle());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Execute-issue stage sitting directly upstream of the 32-bit ALU.
- Holds the 32x32 architectural register file and the ID/EX pipeline register.
- Accepts decoded instructions over a valid/ready handshake, resolves operands (register file, writeback bypass, ALU-result forwarding, immediate), and presents registered A, B and mode to the ALU.
- Sanitises the mode code and shift amounts so the ALU only sees defined operations.

Parameters:
- XLEN, 32, datapath width (A, B, immediate, register contents).
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.
- MODE_W, 4, ALU mode width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of the held instruction.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can capture this cycle.
- in_mode  input  4  ALU op: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9-15 reserved.
- in_rs1  input  5  source register for A.
- in_rs2  input  5  source register for B.
- in_rd  input  5  destination register.
- in_imm  input  32  immediate.
- in_use_imm  input  1  B takes in_imm instead of rs2.
- out_valid  output  1  held instruction valid.
- out_ready  input  1  downstream accepts the held instruction.
- out_a  output  32  ALU operand A.
- out_b  output  32  ALU operand B.
- out_mode  output  4  ALU mode.
- out_rd  output  5  destination of the held instruction.
- out_illegal  output  1  held instruction had a reserved mode.
- alu_x  input  32  ALU result for the held instruction (combinational from out_a/out_b/out_mode).
- wb_en  input  1  register write enable.
- wb_rd  input  5  write index.
- wb_data  input  32  write data.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0: out_valid, out_a, out_b, out_mode, out_rd, out_illegal.
  - All registers 0.
  - in_ready = 0 while in reset.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready), combinational.
  - capture = in_valid && in_ready. On capture, all out_* load at the next edge and out_valid becomes 1.
  - Transfer = out_valid && out_ready. Transfer without capture gives out_valid = 0 next cycle.
  - While out_valid && !out_ready, every out_* holds stable.
- Flush:
  - Next edge gives out_valid = 0 and no capture, regardless of out_ready or in_valid.
  - out_a, out_b, out_mode, out_rd, out_illegal keep their values; they are don't-care while invalid.
- Register file:
  - 2 read ports, 1 write port.
  - Write at the edge when wb_en && wb_rd != 0.
  - Register x0 always reads 0; writes to it are ignored.
- Operand resolution, per source rs (rs1 and rs2 independently), highest priority first:
  - rs == 0 -> 0.
  - EX forward: out_valid && out_ready && out_rd == rs && out_rd != 0 -> alu_x.
  - WB bypass: wb_en && wb_rd == rs -> wb_data, so a same-cycle write is seen.
  - Otherwise -> register file.
- B selection: in_use_imm ? in_imm : resolved rs2.
- System contract: the downstream stage drives wb_* for a transferred instruction exactly one cycle after the transfer. EX forward plus WB bypass therefore cover all ALU RAW hazards with no stall.
- Mode sanitising:
  - in_mode > 8 -> out_mode = 0 (NOP), out_illegal = 1.
  - Otherwise out_mode = in_mode, out_illegal = 0.
- Shift sanitising: for modes 6, 7 and 8, out_b = {27'b0, B[4:0]}.
- Latency: one cycle from capture to operands on out_*. Sustains one instruction per cycle when out_ready = 1 continuously.

Decomposition:
- Package alu_pkg:
  - Mode constants ALU_NOP..ALU_SRA (0-8) and ALU_MODE_MAX = 8.
  - XLEN, MODE_W, REG_IDX_W.
  - Shared with the ALU.
- One sub-module, reg_file:
  - 2R1W, async-reset, x0 hardwired to 0.
  - Write-through bypass lives in the parent.

Test Plan:
- Reset, then write x5 = 0x0000_0010 via wb. Issue ADD rs1=5, use_imm, imm=0x3 -> next cycle out_valid=1, out_a=0x10, out_b=0x3, out_mode=1.
- Back-to-back dependency:
  - Instr1 ADD rd=7, with alu_x=0x55 while held and out_ready=1.
  - Instr2 reads rs1=7 in the same cycle -> out_a=0x55 (EX forward).
  - The next cycle drives wb_rd=7, wb_data=0x55.
  - Instr3 reading rs2=7 -> out_b=0x55 (WB bypass).
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable. Raise out_ready -> new capture the following edge.
- Reserved mode and shifts:
  - in_mode=12 -> out_mode=0, out_illegal=1.
  - SRA with imm=0xFFFF_FFE3 -> out_b=0x0000_0003.
- x0 rules: wb_en, wb_rd=0, wb_data=0xDEAD_BEEF, then read rs1=0 -> out_a=0. Also out_rd=0 held with alu_x=0x1234 and rs1=0 -> out_a=0.
- Flush and reset mid-operation:
  - Flush while out_valid=1, out_ready=0, in_valid=1 -> next cycle out_valid=0, no capture.
  - rst_n low mid-stream -> outputs 0 immediately; a register previously written reads 0 after reset.
